// File: rtl/hqm_aw_rr_arb_hold_pkg.sv
// Shared helpers for the round-robin hold arbiter.
// Width derivation used by the arbiter, its interface and encoder.
package hqm_aw_rr_arb_hold_pkg;

  function automatic int aw_logb2(input int v);
    int r;
    r = 0;
    for (int t = v; t > 1; t = t >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/hqm_aw_rr_arb_hold_if.sv
// Request/grant bundle between requesters, arbiter and consumer.
// slave = arbiter side, master = requester/consumer side.
interface hqm_aw_rr_arb_hold_if
  import hqm_aw_rr_arb_hold_pkg::*;
#(
  parameter  int NUM_REQS    = 8,
  localparam int NUM_REQS_B2 = aw_logb2(NUM_REQS - 1) + 1
);

  logic [NUM_REQS-1:0]    req;
  logic                   gnt_rdy;
  logic                   gnt_v;
  logic [NUM_REQS_B2-1:0] gnt_id;
  logic [NUM_REQS-1:0]    gnt_onehot;

  modport master (
    output req,
    output gnt_rdy,
    input  gnt_v,
    input  gnt_id,
    input  gnt_onehot
  );

  modport slave (
    input  req,
    input  gnt_rdy,
    output gnt_v,
    output gnt_id,
    output gnt_onehot
  );

endinterface

// File: rtl/hqm_aw_rr_arb_hold_binenc.sv
// Priority binary encoder with an any-bit flag.
// MSB=0 picks the lowest set bit, MSB=1 the highest.
module hqm_aw_rr_arb_hold_binenc
  import hqm_aw_rr_arb_hold_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  bit MSB   = 1'b0,
  localparam int ENC_W = aw_logb2(WIDTH - 1) + 1
) (
  input  logic [WIDTH-1:0] a,
  output logic [ENC_W-1:0] enc,
  output logic             any
);

  assign any = |a;

  if (MSB) begin : g_msb
    always_comb begin
      enc = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (a[i]) enc = ENC_W'(i);
      end
    end
  end else begin : g_lsb
    // Scan downward so the lowest set bit is written last.
    always_comb begin
      enc = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (a[i]) enc = ENC_W'(i);
      end
    end
  end

endmodule

// File: rtl/hqm_aw_rr_arb_hold.sv
// Registered round-robin arbiter; grant held until accepted.
// Pointer advances past the accepted id for zero-bubble fairness.
module hqm_aw_rr_arb_hold
  import hqm_aw_rr_arb_hold_pkg::*;
#(
  parameter  int NUM_REQS    = 8,
  localparam int NUM_REQS_B2 = aw_logb2(NUM_REQS - 1) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hqm_aw_rr_arb_hold_if.slave   arb
);

  logic [NUM_REQS_B2-1:0] ptr;
  logic [NUM_REQS_B2-1:0] id_inc;
  logic [NUM_REQS_B2-1:0] eff_ptr;
  logic [NUM_REQS_B2-1:0] hi_enc;
  logic [NUM_REQS_B2-1:0] req_enc;
  logic [NUM_REQS_B2-1:0] win_id;
  logic [NUM_REQS-1:0]    low_mask;
  logic [NUM_REQS-1:0]    hi;
  logic [NUM_REQS-1:0]    win_oh;
  logic                   accept;
  logic                   load;
  logic                   hi_any;
  logic                   req_any;

  assign accept = arb.gnt_v & arb.gnt_rdy;
  assign load   = ~arb.gnt_v | arb.gnt_rdy;

  // Explicit wrap: NUM_REQS need not be a power of two.
  assign id_inc =
    (arb.gnt_id == NUM_REQS_B2'(NUM_REQS - 1))
      ? '0
      : arb.gnt_id + 1'b1;

  assign eff_ptr = accept ? id_inc : ptr;

  always_comb begin
    low_mask = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      low_mask[i] = NUM_REQS_B2'(i) < eff_ptr;
    end
  end

  assign hi = arb.req & ~low_mask;

  hqm_aw_rr_arb_hold_binenc #(
    .WIDTH (NUM_REQS),
    .MSB   (1'b0)
  ) u_enc_hi (
    .a   (hi),
    .enc (hi_enc),
    .any (hi_any)
  );

  hqm_aw_rr_arb_hold_binenc #(
    .WIDTH (NUM_REQS),
    .MSB   (1'b0)
  ) u_enc_req (
    .a   (arb.req),
    .enc (req_enc),
    .any (req_any)
  );

  assign win_id = hi_any ? hi_enc : req_enc;
  assign win_oh = NUM_REQS'(1) << win_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb.gnt_v      <= 1'b0;
      arb.gnt_id     <= '0;
      arb.gnt_onehot <= '0;
      ptr            <= '0;
    end else begin
      if (accept) ptr <= id_inc;
      if (load) begin
        arb.gnt_v      <= req_any;
        arb.gnt_onehot <= req_any ? win_oh : '0;
        if (req_any) arb.gnt_id <= win_id;
      end
    end
  end

`ifndef INTEL_SVA_OFF
  if (NUM_REQS < 2) begin : g_bad_num_reqs
    $error("NUM_REQS must be greater than 1");
  end

  a_onehot: assert property (
    @(posedge clk) disable iff (!rst_n)
    arb.gnt_onehot ==
      (arb.gnt_v ? (NUM_REQS'(1) << arb.gnt_id) : '0));

  a_hold: assert property (
    @(posedge clk) disable iff (!rst_n)
    arb.gnt_v && !arb.gnt_rdy |=> $stable(arb.gnt_id));

  a_range: assert property (
    @(posedge clk) disable iff (!rst_n)
    arb.gnt_v |-> (32'(arb.gnt_id) < NUM_REQS));
`endif

endmodule

// File: tb/tb_hqm_aw_rr_arb_hold.sv
// Bench for the round-robin hold arbiter at NUM_REQS=4 and 5.
// A rotating-search model is compared every cycle.
module tb_hqm_aw_rr_arb_hold;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] req = '0;
  logic rdy = 1'b0;

  always #5 clk = ~clk;

  hqm_aw_rr_arb_hold_if #(.NUM_REQS(4)) if4 ();
  hqm_aw_rr_arb_hold_if #(.NUM_REQS(5)) if5 ();

  assign if4.req     = req[3:0];
  assign if4.gnt_rdy = rdy;
  assign if5.req     = req;
  assign if5.gnt_rdy = rdy;

  hqm_aw_rr_arb_hold #(.NUM_REQS(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (if4.slave)
  );

  hqm_aw_rr_arb_hold #(.NUM_REQS(5)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (if5.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit m4_v, m5_v;
  int m4_id, m4_ptr, m5_id, m5_ptr;

  // Grant goes to the first requester found walking
  // round the ring from the priority start point.
  function automatic void step(
    input  int         n,
    input  logic [4:0] r,
    input  logic       rd,
    input  bit         v,
    input  int         id,
    input  int         ptr,
    output bit         nv,
    output int         nid,
    output int         nptr
  );
    int start;
    nv   = v;
    nid  = id;
    nptr = ptr;
    if (v && rd) nptr = (id + 1) % n;
    if (!v || rd) begin
      start = nptr;
      nv = 1'b0;
      for (int k = 0; k < n; k++) begin
        int c;
        c = (start + k) % n;
        if (!nv && r[c]) begin
          nv  = 1'b1;
          nid = c;
        end
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin : mdl
    bit v4n, v5n;
    int i4n, p4n, i5n, p5n;
    if (!rst_n) begin
      m4_v <= 1'b0; m4_id <= 0; m4_ptr <= 0;
      m5_v <= 1'b0; m5_id <= 0; m5_ptr <= 0;
    end else begin
      step(4, req, rdy, m4_v, m4_id, m4_ptr,
           v4n, i4n, p4n);
      step(5, req, rdy, m5_v, m5_id, m5_ptr,
           v5n, i5n, p5n);
      m4_v <= v4n; m4_id <= i4n; m4_ptr <= p4n;
      m5_v <= v5n; m5_id <= i5n; m5_ptr <= p5n;
    end
  end

  task automatic check(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [31:0] oh(input bit v, input int id);
    return v ? (32'd1 << id) : 32'd0;
  endfunction

  always @(negedge clk) begin
    check("cmp4.v",  32'(if4.gnt_v),      32'(m4_v));
    check("cmp4.id", 32'(if4.gnt_id),     32'(m4_id));
    check("cmp4.oh", 32'(if4.gnt_onehot), oh(m4_v, m4_id));
    check("cmp5.v",  32'(if5.gnt_v),      32'(m5_v));
    check("cmp5.id", 32'(if5.gnt_id),     32'(m5_id));
    check("cmp5.oh", 32'(if5.gnt_onehot), oh(m5_v, m5_id));
  end

  // Literal expectations: pin both the DUTs and the model.
  task automatic look(
    input string nm,
    input bit v4, input int id4,
    input bit v5, input int id5
  );
    check({nm, ".v4"},   32'(if4.gnt_v),      32'(v4));
    check({nm, ".id4"},  32'(if4.gnt_id),     32'(id4));
    check({nm, ".oh4"},  32'(if4.gnt_onehot), oh(v4, id4));
    check({nm, ".v5"},   32'(if5.gnt_v),      32'(v5));
    check({nm, ".id5"},  32'(if5.gnt_id),     32'(id5));
    check({nm, ".oh5"},  32'(if5.gnt_onehot), oh(v5, id5));
    check({nm, ".mv4"},  32'(m4_v),  32'(v4));
    check({nm, ".mid4"}, 32'(m4_id), 32'(id4));
    check({nm, ".mv5"},  32'(m5_v),  32'(v5));
    check({nm, ".mid5"}, 32'(m5_id), 32'(id5));
  endtask

  task automatic chk(
    input string nm,
    input bit v4, input int id4,
    input bit v5, input int id5
  );
    @(posedge clk);
    #2;
    look(nm, v4, id4, v5, id5);
  endtask

  task automatic drive(input logic [4:0] r, input logic rd);
    @(negedge clk);
    req = r;
    rdy = rd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    look("t1_rst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(5'b00000, 1'b0);
    chk("t1_rel", 0, 0, 0, 0);

    for (int k = 0; k < 6; k++) begin
      drive(5'b11111, 1'b1);
      chk("t2_rr", 1, k % 4, 1, k % 5);
    end

    do_reset();
    drive(5'b01010, 1'b0);
    chk("t3_g", 1, 1, 1, 1);
    for (int k = 0; k < 3; k++) begin
      drive(5'b01010, 1'b0);
      chk("t3_hold", 1, 1, 1, 1);
    end
    drive(5'b01010, 1'b1);
    chk("t3_next", 1, 3, 1, 3);
    drive(5'b01010, 1'b1);
    chk("t3_wrap", 1, 1, 1, 1);

    do_reset();
    drive(5'b00100, 1'b1);
    chk("t4_g2", 1, 2, 1, 2);
    drive(5'b00011, 1'b1);
    chk("t4_w0", 1, 0, 1, 0);
    drive(5'b00011, 1'b1);
    chk("t4_w1", 1, 1, 1, 1);

    do_reset();
    drive(5'b00100, 1'b0);
    chk("t5_g", 1, 2, 1, 2);
    drive(5'b00000, 1'b0);
    chk("t5_sticky", 1, 2, 1, 2);
    drive(5'b00000, 1'b1);
    chk("t5_drop", 0, 2, 0, 2);

    do_reset();
    drive(5'b01000, 1'b0);
    chk("t6_g", 1, 3, 1, 3);
    #1;
    rst_n = 1'b0;
    #1;
    look("t6_async", 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(5'b01000, 1'b0);
    chk("t6_after", 1, 3, 1, 3);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      if ($urandom_range(0, 1) == 1) req = 5'($urandom);
      else req = 5'($urandom & $urandom & $urandom);
      rdy = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
